// File: rtl/shift_reg_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_sequencer_pkg
//   Shared encodings for the shift-register sequencer:
//     - MODO_xx       : mode codes understood by the 4-bit universal register
//     - ENABLE/HIGH/LOW : single-bit level names for control pins
//     - state_e       : 2-bit sequencer FSM state codes
//     - cmd_t         : the part of an accepted command held while it executes
// -----------------------------------------------------------------------------
package shift_reg_sequencer_pkg;

    localparam logic [1:0] MODO_00 = 2'b00;   // shift
    localparam logic [1:0] MODO_01 = 2'b01;   // rotate
    localparam logic [1:0] MODO_10 = 2'b10;   // parallel load
    localparam logic [1:0] MODO_11 = 2'b11;   // hold

    localparam logic ENABLE = 1'b1;
    localparam logic HIGH   = 1'b1;
    localparam logic LOW    = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Step count is not kept here; it lives in the capture counter.
    typedef struct packed {
        logic       rot;
        logic       dir;
        logic       sin;
        logic [3:0] data;
    } cmd_t;

endpackage

// File: rtl/shift_reg_sequencer_capture.sv
// -----------------------------------------------------------------------------
// sr_seq_capture
//   Step counter plus S_OUT capture register for the sequencer.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     start_i      : new command accepted; clears captured bits, loads cnt_i
//     step_i       : one shift/rotate step happens at this edge
//     s_out_i      : register serial output, captured at bit index = steps done
//     cnt_i        : requested number of steps
//     bits_o       : captured bits, bit0 = first step
//     last_o       : exactly one step remains (current step is the final one)
//     done_o       : no steps remain
// -----------------------------------------------------------------------------
module sr_seq_capture
    import shift_reg_sequencer_pkg::*;
#(
    parameter int CNT_W  = 3,
    parameter int BITS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              step_i,
    input  logic              s_out_i,
    input  logic [CNT_W-1:0]  cnt_i,
    output logic [BITS_W-1:0] bits_o,
    output logic              last_o,
    output logic              done_o
);

    logic [CNT_W-1:0]  remain_q, remain_d;
    logic [CNT_W-1:0]  idx_q,    idx_d;
    logic [BITS_W-1:0] bits_q,   bits_d;

    // Next-state for counter and capture register. Bits are cleared on start,
    // so OR-ing the new bit into its slot is enough to place it.
    always_comb begin
        remain_d = remain_q;
        idx_d    = idx_q;
        bits_d   = bits_q;
        if (start_i) begin
            remain_d = cnt_i;
            idx_d    = '0;
            bits_d   = '0;
        end else if (step_i && (remain_q != '0)) begin
            bits_d   = bits_q | (BITS_W'(s_out_i) << idx_q);
            idx_d    = idx_q + CNT_W'(1);
            remain_d = remain_q - CNT_W'(1);
        end
    end

    // Counter and capture state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_q <= '0;
            idx_q    <= '0;
            bits_q   <= '0;
        end else begin
            remain_q <= remain_d;
            idx_q    <= idx_d;
            bits_q   <= bits_d;
        end
    end

    assign bits_o = bits_q;
    assign last_o = (remain_q == CNT_W'(1)) ? HIGH : LOW;
    assign done_o = (remain_q == '0) ? HIGH : LOW;

endmodule

// File: rtl/shift_reg_sequencer.sv
// -----------------------------------------------------------------------------
// shift_reg_sequencer
//   Command-driven controller for a 4-bit universal shift register. Each
//   accepted command parallel-loads a nibble, then applies CMD_CNT shift or
//   rotate steps, capturing every S_OUT bit. Final Q and captured bits are
//   returned on a response handshake.
//   Ports:
//     CLK, RESET_L          : clock, asynchronous active-low reset
//     CMD_VALID/CMD_READY   : command handshake (READY only when idle)
//     CMD_ROT, CMD_DIR,
//     CMD_SIN, CMD_DATA,
//     CMD_CNT               : rotate/shift, direction (1=right), serial-in,
//                             load nibble, step count
//     RSP_VALID/RSP_READY   : response handshake, held until accepted
//     RSP_Q, RSP_BITS       : final register value, captured S_OUT bits
//     ENB, DIR, S_IN,
//     MODO, D               : register control outputs
//     Q, S_OUT              : register outputs fed back
// -----------------------------------------------------------------------------
module shift_reg_sequencer
    import shift_reg_sequencer_pkg::*;
#(
    parameter int CNT_W  = 3,
    parameter int BITS_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_L,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_ROT,
    input  logic              CMD_DIR,
    input  logic              CMD_SIN,
    input  logic [3:0]        CMD_DATA,
    input  logic [CNT_W-1:0]  CMD_CNT,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [3:0]        RSP_Q,
    output logic [BITS_W-1:0] RSP_BITS,
    output logic              ENB,
    output logic              DIR,
    output logic              S_IN,
    output logic [1:0]        MODO,
    output logic [3:0]        D,
    input  logic [3:0]        Q,
    input  logic              S_OUT
);

    state_e     state_q,     state_d;
    cmd_t       cmd_q,       cmd_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [3:0] rsp_qval_q,  rsp_qval_d;
    logic       settled_q,   settled_d;

    logic              cap_start;
    logic              cap_step;
    logic              cap_last;
    logic              cap_done;
    logic [BITS_W-1:0] cap_bits;

    sr_seq_capture #(
        .CNT_W  (CNT_W),
        .BITS_W (BITS_W)
    ) u_capture (
        .clk     (CLK),
        .rst_n   (RESET_L),
        .start_i (cap_start),
        .step_i  (cap_step),
        .s_out_i (S_OUT),
        .cnt_i   (CMD_CNT),
        .bits_o  (cap_bits),
        .last_o  (cap_last),
        .done_o  (cap_done)
    );

    // FSM next-state. DONE runs in three phases: first cycle samples the
    // settled Q into RSP_Q, second raises RSP_VALID, then waits for RSP_READY.
    // settled_q tells the first phase apart from the later ones.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_qval_d  = rsp_qval_q;
        settled_d   = settled_q;
        cap_start   = LOW;
        cap_step    = LOW;
        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    cmd_d.rot  = CMD_ROT;
                    cmd_d.dir  = CMD_DIR;
                    cmd_d.sin  = CMD_SIN;
                    cmd_d.data = CMD_DATA;
                    cap_start  = HIGH;
                    settled_d  = LOW;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = cap_done ? ST_DONE : ST_STEP;
            end
            ST_STEP: begin
                cap_step = HIGH;
                if (cap_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!settled_q) begin
                    rsp_qval_d = Q;
                    settled_d  = HIGH;
                end else if (!rsp_valid_q) begin
                    rsp_valid_d = HIGH;
                end else if (RSP_READY) begin
                    rsp_valid_d = LOW;
                    settled_d   = LOW;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and response registers; reset aborts any command in flight.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            rsp_valid_q <= LOW;
            rsp_qval_q  <= '0;
            settled_q   <= LOW;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_qval_q  <= rsp_qval_d;
            settled_q   <= settled_d;
        end
    end

    // Register controls decoded from registered state and latched command
    // only. DIR/S_IN/D sit at zero outside the states that use them.
    always_comb begin
        ENB  = LOW;
        MODO = MODO_11;
        DIR  = LOW;
        S_IN = LOW;
        D    = '0;
        case (state_q)
            ST_LOAD: begin
                ENB  = ENABLE;
                MODO = MODO_10;
                D    = cmd_q.data;
            end
            ST_STEP: begin
                ENB  = ENABLE;
                MODO = cmd_q.rot ? MODO_01 : MODO_00;
                DIR  = cmd_q.dir;
                S_IN = cmd_q.sin;
            end
            default: begin
            end
        endcase
    end

    // READY is gated by RESET_L so it drops the moment reset asserts.
    assign CMD_READY = ((state_q == ST_IDLE) && RESET_L) ? HIGH : LOW;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_Q     = rsp_qval_q;
    assign RSP_BITS  = cap_bits;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_sequencer
//   Bench for shift_reg_sequencer together with a behavioural 4-bit universal
//   shift register. Table-driven vectors, hand-written multi-cycle sequences
//   and random commands checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_shift_reg_sequencer;

    localparam int CNT_W    = 3;
    localparam int BITS_W   = 8;
    localparam int MAX_WAIT = 40;
    localparam int N_VECS   = 6;

    logic              clk = 1'b0;
    logic              reset_l;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rot;
    logic              cmd_dir;
    logic              cmd_sin;
    logic [3:0]        cmd_data;
    logic [CNT_W-1:0]  cmd_cnt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [3:0]        rsp_q;
    logic [BITS_W-1:0] rsp_bits;
    logic              enb;
    logic              dir;
    logic              s_in;
    logic [1:0]        modo;
    logic [3:0]        d;
    logic [3:0]        reg_q;
    logic              s_out;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] q_trace[$];
    int         step_cycles;

    typedef struct {
        logic       rot;
        logic       dir;
        logic       sin;
        logic [3:0] data;
        logic [2:0] cnt;
        logic [3:0] exp_q;
        logic [7:0] exp_bits;
    } vec_t;

    vec_t vecs[N_VECS];

    always #5 clk = ~clk;

    shift_reg_sequencer #(
        .CNT_W  (CNT_W),
        .BITS_W (BITS_W)
    ) dut (
        .CLK       (clk),
        .RESET_L   (reset_l),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_ROT   (cmd_rot),
        .CMD_DIR   (cmd_dir),
        .CMD_SIN   (cmd_sin),
        .CMD_DATA  (cmd_data),
        .CMD_CNT   (cmd_cnt),
        .RSP_VALID (rsp_valid),
        .RSP_READY (rsp_ready),
        .RSP_Q     (rsp_q),
        .RSP_BITS  (rsp_bits),
        .ENB       (enb),
        .DIR       (dir),
        .S_IN      (s_in),
        .MODO      (modo),
        .D         (d),
        .Q         (reg_q),
        .S_OUT     (s_out)
    );

    // Behavioural 4-bit universal shift register driven by the sequencer.
    always @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            reg_q <= 4'b0000;
        end else if (enb) begin
            case (modo)
                2'b10:   reg_q <= d;
                2'b00:   reg_q <= dir ? {s_in, reg_q[3:1]} : {reg_q[2:0], s_in};
                2'b01:   reg_q <= dir ? {reg_q[0], reg_q[3:1]} : {reg_q[2:0], reg_q[3]};
                default: reg_q <= reg_q;
            endcase
        end
    end

    assign s_out = dir ? reg_q[0] : reg_q[3];

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: load the nibble, then per step take the bit leaving the
    // outgoing end and feed in either S_IN (shift) or that same bit (rotate).
    function automatic logic [11:0] refModel(input logic rot, input logic dr,
                                             input logic sin, input logic [3:0] data,
                                             input int cnt);
        int q;
        int bits;
        int outb;
        int fill;
        q    = int'(data);
        bits = 0;
        for (int k = 0; k < cnt; k++) begin
            outb = dr ? (q % 2) : (q / 8);
            fill = rot ? outb : int'(sin);
            q    = dr ? (q / 2 + fill * 8) : ((q * 2) % 16 + fill);
            bits = bits + outb * (1 << k);
        end
        return {4'(q), 8'(bits)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Runs one full command from the idle state and checks latency, step
    // count, response contents and response release. Entered at a negedge.
    task automatic applyStimulus(input logic rot, input logic dr, input logic sin,
                                 input logic [3:0] data, input logic [2:0] cnt,
                                 input logic [3:0] exp_q, input logic [7:0] exp_bits,
                                 input string tag);
        int n;
        int lat;
        n = 0;
        while (!cmd_ready && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_rot   = rot;
        cmd_dir   = dr;
        cmd_sin   = sin;
        cmd_data  = data;
        cmd_cnt   = cnt;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        q_trace.delete();
        step_cycles = 0;
        q_trace.push_back(reg_q);
        if (enb && !modo[1]) step_cycles++;
        lat = 0;
        while (!rsp_valid && lat < MAX_WAIT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            q_trace.push_back(reg_q);
            if (enb && !modo[1]) step_cycles++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(int'(cnt) + 3));
        checkOutput({tag, " steps"}, 32'(step_cycles), 32'(int'(cnt)));
        checkOutput({tag, " rsp_q"}, 32'(rsp_q), 32'(exp_q));
        checkOutput({tag, " rsp_bits"}, 32'(rsp_bits), 32'(exp_bits));
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({tag, " rsp_valid release"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [3:0]  exp_trace[6];
        logic [11:0] exp;
        logic        r_rot;
        logic        r_dir;
        logic        r_sin;
        logic [3:0]  r_data;
        logic [2:0]  r_cnt;
        int          n;
        int          bad;

        reset_l   = 1'b0;
        cmd_valid = 1'b0;
        cmd_rot   = 1'b0;
        cmd_dir   = 1'b0;
        cmd_sin   = 1'b0;
        cmd_data  = 4'b0000;
        cmd_cnt   = 3'd0;
        rsp_ready = 1'b0;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 4'b1000, 3'd4, 4'b0000, 8'b00001000};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 4'b1001, 3'd1, 4'b0011, 8'b00000001};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 4'b0110, 3'd0, 4'b0110, 8'b00000000};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 4'b0000, 3'd7, 4'b1111, 8'b01110000};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 4'b1011, 3'd2, 4'b1110, 8'b00000011};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 4'b0101, 3'd3, 4'b1111, 8'b00000010};

        exp_trace[0] = 4'b0000;
        exp_trace[1] = 4'b1000;
        exp_trace[2] = 4'b0100;
        exp_trace[3] = 4'b0010;
        exp_trace[4] = 4'b0001;
        exp_trace[5] = 4'b0000;

        // Reset values while RESET_L is low.
        #12;
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("reset controls", 32'({enb, modo, dir, s_in, d}), 32'({1'b0, 2'b11, 1'b0, 1'b0, 4'b0000}));
        checkOutput("reset rsp", 32'({rsp_valid, rsp_q, rsp_bits}), 32'd0);
        @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);
        checkOutput("idle cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("idle controls", 32'({enb, modo}), 32'({1'b0, 2'b11}));

        // Per-cycle register trace for load 1000, right shift, 4 steps.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b1000, 3'd4, 4'b0000, 8'b00001000, "trace");
        for (int k = 1; k < 6; k++) begin
            checkOutput($sformatf("q trace %0d", k),
                        (q_trace.size() > k) ? 32'(q_trace[k]) : 32'hFFFF_FFFF,
                        32'(exp_trace[k]));
        end

        // Table-driven vectors.
        for (int i = 0; i < N_VECS; i++) begin
            applyStimulus(vecs[i].rot, vecs[i].dir, vecs[i].sin, vecs[i].data,
                          vecs[i].cnt, vecs[i].exp_q, vecs[i].exp_bits,
                          $sformatf("vec%0d", i));
        end

        // Backpressure: response held with RSP_READY low while another
        // command waits on CMD_VALID; it is taken only after IDLE returns.
        cmd_valid = 1'b1;
        cmd_rot   = 1'b0;
        cmd_dir   = 1'b0;
        cmd_sin   = 1'b0;
        cmd_data  = 4'b1011;
        cmd_cnt   = 3'd2;
        @(posedge clk);
        @(negedge clk);
        cmd_dir  = 1'b1;
        cmd_sin  = 1'b1;
        cmd_data = 4'b1011;
        cmd_cnt  = 3'd1;
        n   = 0;
        bad = 0;
        while (!rsp_valid && n < MAX_WAIT) begin
            if (cmd_ready) bad++;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        checkOutput("bp busy cmd_ready", 32'(bad), 32'd0);
        checkOutput("bp first rsp", 32'({rsp_valid, rsp_q, rsp_bits}), 32'({1'b1, 4'b1100, 8'b00000001}));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("bp hold %0d", c),
                        32'({rsp_valid, cmd_ready, rsp_q, rsp_bits}),
                        32'({1'b1, 1'b0, 4'b1100, 8'b00000001}));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp idle gap", 32'({cmd_ready, rsp_valid}), 32'({1'b1, 1'b0}));
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("bp second load", 32'({enb, modo, d}), 32'({1'b1, 2'b10, 4'b1011}));
        // RSP_READY stays high before the response exists; it must not
        // shortcut the response.
        n = 0;
        while (!rsp_valid && n < MAX_WAIT) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checkOutput("bp second latency", 32'(n), 32'd4);
        checkOutput("bp second rsp", 32'({rsp_q, rsp_bits}), 32'({4'b1101, 8'b00000001}));
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("bp second release", 32'(rsp_valid), 32'd0);

        // Reset asserted mid-STEP aborts the command.
        cmd_valid = 1'b1;
        cmd_rot   = 1'b0;
        cmd_dir   = 1'b1;
        cmd_sin   = 1'b0;
        cmd_data  = 4'b1111;
        cmd_cnt   = 3'd7;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("abort pre step", 32'({enb, modo, rsp_bits}), 32'({1'b1, 2'b00, 8'b00000011}));
        #2;
        reset_l = 1'b0;
        #1;
        checkOutput("abort controls", 32'({enb, modo, dir, s_in, d}), 32'({1'b0, 2'b11, 1'b0, 1'b0, 4'b0000}));
        checkOutput("abort rsp", 32'({cmd_ready, rsp_valid, rsp_q, rsp_bits}), 32'd0);
        @(negedge clk);
        reset_l = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid || enb) bad++;
        end
        checkOutput("abort quiet", 32'(bad), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b1100, 3'd3, 4'b0110, 8'b00000011, "post reset");

        // Random commands against the reference model.
        for (int i = 0; i < 30; i++) begin
            r_rot  = 1'($urandom_range(0, 1));
            r_dir  = 1'($urandom_range(0, 1));
            r_sin  = 1'($urandom_range(0, 1));
            r_data = 4'($urandom_range(0, 15));
            r_cnt  = 3'($urandom_range(0, 7));
            exp    = refModel(r_rot, r_dir, r_sin, r_data, int'(r_cnt));
            applyStimulus(r_rot, r_dir, r_sin, r_data, r_cnt, exp[11:8], exp[7:0],
                          $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
